// File: rtl/vend_pkg.sv
// Shared types and constants for the drink vending controller: drink/coin codes,
// sequencer states and the change denominations.
package vend_pkg;

  typedef enum logic [1:0] {TEA = 2'b00, COKE = 2'b01, COFFEE = 2'b10, MILK = 2'b11} drink_e;
  typedef enum logic [1:0] {COIN_1 = 2'b00, COIN_5 = 2'b01, COIN_10 = 2'b10, COIN_50 = 2'b11} coin_e;
  typedef enum logic [1:0] {COLLECT = 2'b00, DISPENSE = 2'b01, CHANGE = 2'b10} state_e;

  localparam logic [5:0] DENOM_10 = 6'd10;
  localparam logic [5:0] DENOM_5  = 6'd5;
  localparam logic [5:0] DENOM_1  = 6'd1;

  function automatic logic [5:0] coin_val(input logic [1:0] code);
    case (coin_e'(code))
      COIN_1:  return 6'd1;
      COIN_5:  return 6'd5;
      COIN_10: return 6'd10;
      default: return 6'd50;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change picker: largest of 10/5/1 not exceeding the remaining credit,
// zero when nothing is owed.
module vend_change_sel
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [5:0]          change_coin
);

  always_comb begin
    change_coin = 6'd0;
    if (credit >= CREDIT_W'(DENOM_10))     change_coin = DENOM_10;
    else if (credit >= CREDIT_W'(DENOM_5)) change_coin = DENOM_5;
    else if (credit != '0)                 change_coin = DENOM_1;
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending sequencer: collects coin credit, sells one drink per selection over a
// valid/ready handshake, then pays back the remaining credit one coin at a time.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_W     = 8,
  parameter int MAX_CREDIT   = 200,
  parameter int PRICE_TEA    = 10,
  parameter int PRICE_COKE   = 15,
  parameter int PRICE_COFFEE = 20,
  parameter int PRICE_MILK   = 25
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_value,
  output logic                coin_reject,
  input  logic                sel_valid,
  input  logic [1:0]          sel_drink,
  output logic                sel_deny,
  input  logic                cancel,
  output logic                drink_valid,
  output logic [1:0]          drink_id,
  input  logic                drink_ready,
  output logic                change_valid,
  output logic [5:0]          change_coin,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] total_coin,
  output logic                busy
);

  localparam int SUM_W = CREDIT_W + 1;

  if (MAX_CREDIT >= (1 << CREDIT_W)) begin : g_credit_range_check
    $error("vend_ctrl: MAX_CREDIT does not fit in CREDIT_W bits");
  end

  state_e              state, state_n;
  logic [CREDIT_W-1:0] credit, credit_n, price;
  logic [1:0]          drink_id_n;
  logic                coin_reject_n, sel_deny_n, drink_valid_n, change_valid_n, busy_n;
  logic [SUM_W-1:0]    base, coin_sum;

  vend_change_sel #(.CREDIT_W(CREDIT_W)) u_change_sel (
    .credit      (credit),
    .change_coin (change_coin)
  );

  always_comb begin
    case (drink_e'(sel_drink))
      TEA:     price = CREDIT_W'(PRICE_TEA);
      COKE:    price = CREDIT_W'(PRICE_COKE);
      COFFEE:  price = CREDIT_W'(PRICE_COFFEE);
      default: price = CREDIT_W'(PRICE_MILK);
    endcase
  end

  always_comb begin
    state_n       = state;
    credit_n      = credit;
    drink_id_n    = drink_id;
    coin_reject_n = 1'b0;
    sel_deny_n    = 1'b0;
    base          = {1'b0, credit};
    coin_sum      = '0;
    case (state)
      COLLECT: begin
        if (cancel) begin
          // Cancel wins the cycle: any coin alongside it goes straight back.
          coin_reject_n = coin_valid;
          if (credit != '0) state_n = CHANGE;
        end else begin
          if (sel_valid && (price <= credit)) begin
            base       = {1'b0, credit - price};
            drink_id_n = sel_drink;
            state_n    = DISPENSE;
          end else if (sel_valid) begin
            sel_deny_n = 1'b1;
          end
          if (coin_valid) begin
            coin_sum = base + SUM_W'(coin_val(coin_value));
            if (coin_sum <= SUM_W'(MAX_CREDIT)) base = coin_sum;
            else coin_reject_n = 1'b1;
          end
          credit_n = base[CREDIT_W-1:0];
        end
      end
      DISPENSE: begin
        coin_reject_n = coin_valid;
        sel_deny_n    = sel_valid;
        if (drink_valid && drink_ready) state_n = (credit != '0) ? CHANGE : COLLECT;
      end
      CHANGE: begin
        coin_reject_n = coin_valid;
        sel_deny_n    = sel_valid;
        if (credit == '0) begin
          state_n = COLLECT;
        end else if (change_valid && change_ready) begin
          credit_n = credit - CREDIT_W'(change_coin);
          if (credit_n == '0) state_n = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
    drink_valid_n  = (state_n == DISPENSE);
    change_valid_n = (state_n == CHANGE) && (credit_n != '0);
    busy_n         = (state_n != COLLECT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= COLLECT;
      credit       <= '0;
      drink_id     <= 2'b00;
      coin_reject  <= 1'b0;
      sel_deny     <= 1'b0;
      drink_valid  <= 1'b0;
      change_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      credit       <= credit_n;
      drink_id     <= drink_id_n;
      coin_reject  <= coin_reject_n;
      sel_deny     <= sel_deny_n;
      drink_valid  <= drink_valid_n;
      change_valid <= change_valid_n;
      busy         <= busy_n;
    end
  end

  assign total_coin = credit;

endmodule
